// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions. The capture path, the pixel output path
// and any other frame-buffer user import this package so that pixel format,
// default raster size and status encoding stay consistent.
//   pixel_t          24-bit RGB 8:8:8 pixel
//   H/V_ACTIVE_DEF   default active raster size
//   cap_state_t      capture FSM states
//   STAT_*           bit positions inside the 2-bit capture status word
package fb_pkg;

    localparam int PIXEL_W = 24;
    typedef logic [PIXEL_W-1:0] pixel_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2
    } cap_state_t;

    // status = {overflow, overrun}
    localparam int STAT_OVERRUN  = 0;  // pixel beyond H_ACTIVE on a line
    localparam int STAT_OVERFLOW = 1;  // pixel dropped because the FIFO was full

endpackage

// File: rtl/frame_capture_if.sv
// Bundle of the pixel-stream input and frame-buffer write port of
// frame_capture.
//   pixelData/pixelValid/frameStart/lineEnd  raster pixel stream
//   memAddress/memData/memWrite/memReady     single-word write port
//   frameDone/frameError/status              frame completion and error flags
// slave  : the capture block
// master : the environment (pixel source plus memory)
interface frame_capture_if #(
    parameter int ADDR_WIDTH = 19
);
    fb_pkg::pixel_t          pixelData;
    logic                    pixelValid;
    logic                    frameStart;
    logic                    lineEnd;
    logic [ADDR_WIDTH-1:0]   memAddress;
    fb_pkg::pixel_t          memData;
    logic                    memWrite;
    logic                    memReady;
    logic                    frameDone;
    logic                    frameError;
    logic [1:0]              status;

    modport slave (
        input  pixelData, pixelValid, frameStart, lineEnd, memReady,
        output memAddress, memData, memWrite, frameDone, frameError, status
    );

    modport master (
        output pixelData, pixelValid, frameStart, lineEnd, memReady,
        input  memAddress, memData, memWrite, frameDone, frameError, status
    );
endinterface

// File: rtl/fb_write_fifo.sv
// Pending-write FIFO with a registered head. head_data/head_valid are flops
// loaded with the entry that will be at the head after each edge, so a push
// into an empty FIFO is visible one cycle later and nothing combinational
// reaches the outputs.
//   clock, reset          clock, asynchronous active-high reset
//   flush                 discard all entries (a simultaneous push is kept)
//   push, push_data       write one entry; accepted when not full or popping
//   pop                   remove the head entry
//   full, empty, one_left occupancy flags
//   head_data, head_valid current head entry
// DEPTH must be a power of two so the pointers wrap naturally.
module fb_write_fifo #(
    parameter int WIDTH = 43,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             one_left,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, wr_idx, wr_ptr_n, rd_ptr_n;
    logic [CW-1:0]    count, count_n;
    logic             do_push, do_pop;

    assign full     = (count == COUNT_FULL);
    assign empty    = (count == '0);
    assign one_left = (count == CW'(1));

    always_comb begin
        do_pop   = pop && !empty && !flush;
        // a full FIFO still takes a push when the head leaves in the same cycle
        do_push  = push && (flush || !full || do_pop);
        wr_idx   = flush ? '0 : wr_ptr;
        rd_ptr_n = flush ? '0 : (do_pop ? rd_ptr + PW'(1) : rd_ptr);
        wr_ptr_n = wr_idx + PW'(do_push);
        count_n  = (flush ? '0 : count) + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            count      <= count_n;
            head_valid <= (count_n != '0);
            // the new head is the entry being written now when it lands in
            // the head slot, otherwise it is already in storage
            if (count_n != '0)
                head_data <= (do_push && (wr_idx == rd_ptr_n)) ? push_data : store[rd_ptr_n];
        end
    end

    always_ff @(posedge clock) begin
        if (do_push)
            store[wr_idx] <= push_data;
    end

endmodule

// File: rtl/frame_capture.sv
// Receive side of the 24-bit pixel path: turns a raster pixel stream with
// frame-start / line-end markers into single-word frame-buffer writes.
//   clock, reset  sole clock, asynchronous active-high reset
//   bus           frame_capture_if slave: pixel stream in, memory write port
//                 out, plus frameDone / frameError pulses and sticky status
// x counts pixels on the current line, y counts lines, line_base is the
// address of (0,y) and next_addr the address of the next accepted pixel.
module frame_capture
    import fb_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int ADDR_WIDTH = 19,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    frame_capture_if.slave bus
);
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int EW = ADDR_WIDTH + PIXEL_W;

    localparam logic [XW-1:0]         X_END  = XW'(H_ACTIVE);
    localparam logic [XW-1:0]         X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]         Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [ADDR_WIDTH-1:0] A_BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] A_STEP = ADDR_WIDTH'(H_ACTIVE);

    cap_state_t            state, state_n;
    logic [XW-1:0]         x, x_n, cx;
    logic [YW-1:0]         y, y_n, cy;
    logic [ADDR_WIDTH-1:0] line_base, base_n, cbase;
    logic [ADDR_WIDTH-1:0] next_addr, addr_n, caddr;
    logic [1:0]            status, status_n, cstat;
    logic                  frame_done, frame_done_n;
    logic                  frame_error, frame_error_n;
    logic                  active, room, push, pop;
    logic                  full, empty, one_left;
    logic [EW-1:0]         head_data;
    logic                  head_valid;

    assign pop = head_valid && bus.memReady;

    fb_write_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (bus.frameStart),
        .push       (push),
        .push_data  ({caddr, bus.pixelData}),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .one_left   (one_left),
        .head_data  (head_data),
        .head_valid (head_valid)
    );

    always_comb begin
        state_n       = state;
        frame_done_n  = 1'b0;
        frame_error_n = 1'b0;
        push          = 1'b0;
        active        = (state == ST_CAPTURE);
        room          = !full || pop;
        cx            = x;
        cy            = y;
        cbase         = line_base;
        caddr         = next_addr;
        cstat         = status;

        // frameStart restarts from any state; the cycle's pixel, if any, is
        // then evaluated against the fresh (0,0) context and an empty FIFO
        if (bus.frameStart) begin
            frame_error_n = (state != ST_IDLE);
            state_n       = ST_CAPTURE;
            active        = 1'b1;
            room          = 1'b1;
            cx            = '0;
            cy            = '0;
            cbase         = A_BASE;
            caddr         = A_BASE;
            cstat         = '0;
        end

        x_n      = cx;
        y_n      = cy;
        base_n   = cbase;
        addr_n   = caddr;
        status_n = cstat;

        if (active) begin
            if (bus.pixelValid) begin
                if (cx == X_END) begin
                    status_n[STAT_OVERRUN] = 1'b1;
                end else begin
                    // a dropped pixel still consumes its address slot
                    if (room)
                        push = 1'b1;
                    else
                        status_n[STAT_OVERFLOW] = 1'b1;
                    x_n    = cx + XW'(1);
                    addr_n = caddr + ADDR_WIDTH'(1);
                    if ((cx == X_LAST) && (cy == Y_LAST))
                        state_n = ST_FLUSH;
                end
            end
            // a lineEnd in the frameStart cycle would mis-place the new frame
            if (bus.lineEnd && !bus.frameStart) begin
                if (cy == Y_LAST) begin
                    state_n = ST_FLUSH;
                end else begin
                    x_n    = '0;
                    y_n    = cy + YW'(1);
                    base_n = cbase + A_STEP;
                    addr_n = cbase + A_STEP;
                end
            end
        end else if (state == ST_FLUSH) begin
            // done is registered, so look one pop ahead to pulse it in the
            // cycle right after the final write is accepted
            if (empty || (one_left && pop)) begin
                frame_done_n = 1'b1;
                state_n      = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            x           <= '0;
            y           <= '0;
            line_base   <= A_BASE;
            next_addr   <= A_BASE;
            status      <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            x           <= x_n;
            y           <= y_n;
            line_base   <= base_n;
            next_addr   <= addr_n;
            status      <= status_n;
            frame_done  <= frame_done_n;
            frame_error <= frame_error_n;
        end
    end

    assign bus.memAddress = head_data[EW-1:PIXEL_W];
    assign bus.memData    = head_data[PIXEL_W-1:0];
    assign bus.memWrite   = head_valid;
    assign bus.frameDone  = frame_done;
    assign bus.frameError = frame_error;
    assign bus.status     = status;

endmodule

// File: tb/tb_frame_capture.sv
`timescale 1ns/1ps
module tb_frame_capture;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int BASE  = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    frame_capture_if #(.ADDR_WIDTH(AW)) bus ();

    frame_capture #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic          fs;
        logic          pv;
        logic          le;
        logic          rdy;
        logic [23:0]   pix;
        logic          exp_wr;
        logic [AW-1:0] exp_addr;
    } vec_t;

    typedef struct {
        int         lo;
        int         hi;
        logic [1:0] exp_status;
    } seg_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [23:0]   data;
    } wr_t;

    vec_t tbl[$];
    seg_t segs[$];
    wr_t  sb[$];

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int wr_cnt   = 0;

    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr  = '0;
    logic [23:0]   prev_data  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard compare of accepted writes, stall stability, pulse counts
    always @(negedge clock) begin : monitor
        wr_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.frameDone)  done_cnt++;
            if (bus.frameError) err_cnt++;
            if (prev_stall) begin
                check("stall_hold_write", {31'd0, bus.memWrite}, 32'd1);
                check("stall_hold_addr", {24'd0, bus.memAddress}, {24'd0, prev_addr});
                check("stall_hold_data", {8'd0, bus.memData}, {8'd0, prev_data});
            end
            if (bus.memWrite && bus.memReady) begin
                wr_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             bus.memAddress, bus.memData);
                end else begin
                    e = sb.pop_front();
                    check("write_addr", {24'd0, bus.memAddress}, {24'd0, e.addr});
                    check("write_data", {8'd0, bus.memData}, {8'd0, e.data});
                end
            end
            prev_stall = bus.memWrite && !bus.memReady && !bus.frameStart;
            prev_addr  = bus.memAddress;
            prev_data  = bus.memData;
        end
    end

    task automatic drive(input logic fs, input logic pv, input logic le, input logic rdy,
                         input logic [23:0] pix);
        @(posedge clock);
        #1;
        bus.frameStart = fs;
        bus.pixelValid = pv;
        bus.lineEnd    = le;
        bus.memReady   = rdy;
        bus.pixelData  = pix;
    endtask

    task automatic expect_wr(input int addr, input logic [23:0] data);
        wr_t w;
        w.addr = AW'(addr);
        w.data = data;
        sb.push_back(w);
    endtask

    task automatic add(input logic fs, input logic pv, input logic le, input logic ew, input int addr);
        vec_t v;
        v.fs       = fs;
        v.pv       = pv;
        v.le       = le;
        v.rdy      = 1'b1;
        v.pix      = 24'($urandom);
        v.exp_wr   = ew;
        v.exp_addr = AW'(addr);
        tbl.push_back(v);
    endtask

    task automatic seg_end(input int lo, input logic [1:0] st);
        seg_t s;
        s.lo         = lo;
        s.hi         = tbl.size() - 1;
        s.exp_status = st;
        segs.push_back(s);
    endtask

    task automatic settle(input int exp_done);
        int n;
        n = 0;
        while ((sb.size() != 0 || done_cnt < exp_done) && n < 60) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic finish_frame(input string name, input int exp_done, input int exp_err,
                                input logic [1:0] exp_status);
        settle(exp_done);
        check({name, "_drained"}, sb.size(), 32'd0);
        check({name, "_frame_done"}, done_cnt, exp_done);
        check({name, "_frame_error"}, err_cnt, exp_err);
        check({name, "_status"}, {30'd0, bus.status}, {30'd0, exp_status});
    endtask

    task automatic run_seg(input int s);
        done_cnt = 0;
        err_cnt  = 0;
        for (int i = segs[s].lo; i <= segs[s].hi; i++) begin
            drive(tbl[i].fs, tbl[i].pv, tbl[i].le, tbl[i].rdy, tbl[i].pix);
            if (tbl[i].exp_wr) expect_wr(int'(tbl[i].exp_addr), tbl[i].pix);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 24'd0);
        finish_frame($sformatf("seg%0d", s), 1, 0, segs[s].exp_status);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int lo;
        int w0;
        logic [23:0] p;

        bus.frameStart = 1'b0;
        bus.pixelValid = 1'b0;
        bus.lineEnd    = 1'b0;
        bus.memReady   = 1'b0;
        bus.pixelData  = '0;

        // seg0 nominal frame
        lo = tbl.size();
        add(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1, BASE + i);
        add(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1, BASE + 4 + i);
        seg_end(lo, 2'b00);
        // seg1 short line 0
        lo = tbl.size();
        add(1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) add(0, 1, 0, 1, BASE + i);
        add(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1, BASE + 4 + i);
        seg_end(lo, 2'b00);
        // seg2 over-long line 0
        lo = tbl.size();
        add(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1, BASE + i);
        add(0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1, BASE + 4 + i);
        seg_end(lo, 2'b01);
        // seg3 pixelValid together with lineEnd on the 4th pixel
        lo = tbl.size();
        add(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 1, BASE + i);
        add(0, 1, 1, 1, BASE + 3);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1, BASE + 4 + i);
        seg_end(lo, 2'b00);
        // seg4 frameStart with pixel, frame ended by lineEnd on the last line
        lo = tbl.size();
        add(1, 1, 0, 1, BASE);
        for (int i = 1; i < 4; i++) add(0, 1, 0, 1, BASE + i);
        add(0, 0, 1, 0, 0);
        add(0, 0, 1, 0, 0);
        seg_end(lo, 2'b00);

        // reset state
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_memWrite", {31'd0, bus.memWrite}, 32'd0);
        check("rst_memAddress", {24'd0, bus.memAddress}, 32'd0);
        check("rst_memData", {8'd0, bus.memData}, 32'd0);
        check("rst_frameDone", {31'd0, bus.frameDone}, 32'd0);
        check("rst_frameError", {31'd0, bus.frameError}, 32'd0);
        check("rst_status", {30'd0, bus.status}, 32'd0);

        // IDLE ignores pixels and lineEnd
        w0 = wr_cnt;
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 24'($urandom));
        drive(0, 0, 1, 1, 24'd0);
        repeat (3) drive(0, 0, 0, 1, 24'd0);
        @(negedge clock);
        check("idle_no_writes", wr_cnt - w0, 32'd0);
        check("idle_status", {30'd0, bus.status}, 32'd0);

        for (int s = 0; s < segs.size(); s++) run_seg(s);

        // back-pressure: FIFO fills, the 5th pixel is dropped
        done_cnt = 0;
        err_cnt  = 0;
        drive(1, 0, 0, 0, 24'd0);
        for (int i = 0; i < 4; i++) begin
            p = 24'($urandom);
            drive(0, 1, 0, 0, p);
            expect_wr(BASE + i, p);
        end
        drive(0, 0, 1, 0, 24'd0);
        drive(0, 1, 0, 0, 24'($urandom));
        repeat (6) drive(0, 0, 0, 0, 24'd0);
        @(negedge clock);
        check("bp_overflow_status", {30'd0, bus.status}, 32'd2);
        check("bp_stall_write", {31'd0, bus.memWrite}, 32'd1);
        check("bp_stall_addr", {24'd0, bus.memAddress}, BASE);
        repeat (5) drive(0, 0, 0, 1, 24'd0);
        for (int i = 1; i < 4; i++) begin
            p = 24'($urandom);
            drive(0, 1, 0, 1, p);
            expect_wr(BASE + 4 + i, p);
        end
        drive(0, 0, 0, 1, 24'd0);
        finish_frame("backpressure", 1, 0, 2'b10);

        // push and pop while full is not an overflow
        done_cnt = 0;
        err_cnt  = 0;
        drive(1, 0, 0, 0, 24'd0);
        for (int i = 0; i < 4; i++) begin
            p = 24'($urandom);
            drive(0, 1, 0, 0, p);
            expect_wr(BASE + i, p);
        end
        drive(0, 0, 1, 0, 24'd0);
        for (int i = 0; i < 4; i++) begin
            p = 24'($urandom);
            drive(0, 1, 0, 1, p);
            expect_wr(BASE + 4 + i, p);
        end
        drive(0, 0, 0, 1, 24'd0);
        finish_frame("full_push_pop", 1, 0, 2'b00);

        // abort mid-line 1 with 3 entries pending
        done_cnt = 0;
        err_cnt  = 0;
        drive(1, 0, 0, 1, 24'd0);
        for (int i = 0; i < 4; i++) begin
            p = 24'($urandom);
            drive(0, 1, 0, 1, p);
            expect_wr(BASE + i, p);
        end
        drive(0, 0, 1, 1, 24'd0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 24'($urandom));
        drive(1, 0, 0, 0, 24'd0);
        repeat (2) drive(0, 0, 0, 0, 24'd0);
        @(negedge clock);
        check("abort_frame_error", err_cnt, 32'd1);
        check("abort_no_frame_done", done_cnt, 32'd0);
        check("abort_fifo_flushed", {31'd0, bus.memWrite}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            p = 24'($urandom);
            drive(0, 1, 0, 1, p);
            expect_wr(BASE + i, p);
        end
        drive(0, 0, 1, 1, 24'd0);
        for (int i = 0; i < 4; i++) begin
            p = 24'($urandom);
            drive(0, 1, 0, 1, p);
            expect_wr(BASE + 4 + i, p);
        end
        drive(0, 0, 0, 1, 24'd0);
        finish_frame("abort_restart", 1, 1, 2'b00);

        // asynchronous reset while a write is stalled
        done_cnt = 0;
        err_cnt  = 0;
        drive(1, 0, 0, 0, 24'd0);
        for (int i = 0; i < 2; i++) drive(0, 1, 0, 0, 24'($urandom));
        drive(0, 0, 0, 0, 24'd0);
        @(negedge clock);
        check("pre_reset_write", {31'd0, bus.memWrite}, 32'd1);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("async_rst_memWrite", {31'd0, bus.memWrite}, 32'd0);
        check("async_rst_memAddress", {24'd0, bus.memAddress}, 32'd0);
        check("async_rst_memData", {8'd0, bus.memData}, 32'd0);
        check("async_rst_status", {30'd0, bus.status}, 32'd0);
        check("async_rst_flags", {30'd0, bus.frameDone, bus.frameError}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        w0 = wr_cnt;
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 24'($urandom));
        repeat (3) drive(0, 0, 0, 1, 24'd0);
        @(negedge clock);
        check("post_reset_idle_writes", wr_cnt - w0, 32'd0);
        check("post_reset_no_done", done_cnt, 32'd0);
        run_seg(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
